// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the LC-3 control unit: state codes, opcodes,
// datapath mux encodings and the packed control word.
package lc3_ctrl_pkg;

  typedef enum logic [5:0] {
    S_BR     = 6'd0,
    S_ADD    = 6'd1,
    S_LD_A   = 6'd2,
    S_ST_A   = 6'd3,
    S_AND    = 6'd5,
    S_NOT    = 6'd9,
    S_JMP    = 6'd12,
    S_LEA    = 6'd14,
    S_ST_M   = 6'd16,
    S_FETCH0 = 6'd18,
    S_BR_T   = 6'd22,
    S_ST_D   = 6'd23,
    S_LD_M   = 6'd25,
    S_LD_W   = 6'd27,
    S_DECODE = 6'd32,
    S_FETCH1 = 6'd33,
    S_FETCH2 = 6'd35,
    S_HALT   = 6'd62,
    S_INIT   = 6'd63
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] SR1_IR11_9 = 2'b00;
  localparam logic [1:0] SR1_IR8_6  = 2'b01;
  localparam logic [1:0] SR1_R6     = 2'b10;

  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_BUS   = 2'b01;
  localparam logic [1:0] PC_ADDER = 2'b10;

  localparam logic [1:0] DR_IR11_9 = 2'b00;

  localparam logic       ADDR1_PC    = 1'b0;
  localparam logic       ADDR1_BASER = 1'b1;

  localparam logic [1:0] A2_ZERO     = 2'b00;
  localparam logic [1:0] A2_OFF6     = 2'b01;
  localparam logic [1:0] A2_PCOFF9   = 2'b10;
  localparam logic [1:0] A2_PCOFF11  = 2'b11;

  localparam logic       MARMUX_ZEXT  = 1'b0;
  localparam logic       MARMUX_ADDER = 1'b1;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic [1:0] drmux;
    logic [1:0] sr1mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       r_w;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH1) || (s == S_LD_M) || (s == S_ST_M);
  endfunction

  function automatic state_t dispatch(input logic [3:0] op);
    case (op)
      OP_ADD:  return S_ADD;
      OP_AND:  return S_AND;
      OP_NOT:  return S_NOT;
      OP_LEA:  return S_LEA;
      OP_LD:   return S_LD_A;
      OP_ST:   return S_ST_A;
      OP_BR:   return S_BR;
      OP_JMP:  return S_JMP;
      default: return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Combinational state -> control-word decode. The FSM feeds it the next
// state so the control word can be registered alongside the state.
module lc3_ctrl_decode
  import lc3_ctrl_pkg::*;
(
  input  state_t state_s,
  output ctrl_t  ctrl_s
);

  // Moore decode: every field is a function of the state code alone.
  always_comb begin
    ctrl_s = CTRL_NONE;
    case (state_s)
      S_FETCH0: begin
        ctrl_s.ld_mar  = 1'b1;
        ctrl_s.gate_pc = 1'b1;
        ctrl_s.ld_pc   = 1'b1;
        ctrl_s.pcmux   = PC_PLUS1;
      end
      S_FETCH1: begin
        ctrl_s.mio_en = 1'b1;
        ctrl_s.ld_mdr = 1'b1;
        ctrl_s.r_w    = 1'b0;
      end
      S_FETCH2: begin
        ctrl_s.gate_mdr = 1'b1;
        ctrl_s.ld_ir    = 1'b1;
      end
      S_DECODE: begin
        ctrl_s.ld_ben = 1'b1;
      end
      // Operand 2 (register vs imm5) is picked in the datapath from ir[5].
      S_ADD, S_AND, S_NOT: begin
        ctrl_s.sr1mux   = SR1_IR8_6;
        ctrl_s.drmux    = DR_IR11_9;
        ctrl_s.gate_alu = 1'b1;
        ctrl_s.ld_reg   = 1'b1;
        ctrl_s.ld_cc    = 1'b1;
        ctrl_s.aluk     = (state_s == S_ADD) ? ALUK_ADD :
                          (state_s == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_LEA: begin
        ctrl_s.addr1mux    = ADDR1_PC;
        ctrl_s.addr2mux    = A2_PCOFF9;
        ctrl_s.marmux      = MARMUX_ADDER;
        ctrl_s.gate_marmux = 1'b1;
        ctrl_s.drmux       = DR_IR11_9;
        ctrl_s.ld_reg      = 1'b1;
      end
      S_LD_A, S_ST_A: begin
        ctrl_s.sr1mux      = SR1_IR8_6;
        ctrl_s.addr1mux    = ADDR1_PC;
        ctrl_s.addr2mux    = A2_PCOFF9;
        ctrl_s.marmux      = MARMUX_ADDER;
        ctrl_s.gate_marmux = 1'b1;
        ctrl_s.ld_mar      = 1'b1;
      end
      S_LD_M: begin
        ctrl_s.mio_en = 1'b1;
        ctrl_s.ld_mdr = 1'b1;
      end
      S_LD_W: begin
        ctrl_s.gate_mdr = 1'b1;
        ctrl_s.drmux    = DR_IR11_9;
        ctrl_s.ld_reg   = 1'b1;
        ctrl_s.ld_cc    = 1'b1;
      end
      // Store data is the SR register passed straight through the ALU.
      S_ST_D: begin
        ctrl_s.sr1mux   = SR1_IR11_9;
        ctrl_s.aluk     = ALUK_PASSA;
        ctrl_s.gate_alu = 1'b1;
        ctrl_s.ld_mdr   = 1'b1;
      end
      S_ST_M: begin
        ctrl_s.mio_en = 1'b1;
        ctrl_s.r_w    = 1'b1;
      end
      S_BR_T: begin
        ctrl_s.addr1mux = ADDR1_PC;
        ctrl_s.addr2mux = A2_PCOFF9;
        ctrl_s.pcmux    = PC_ADDER;
        ctrl_s.ld_pc    = 1'b1;
      end
      S_JMP: begin
        ctrl_s.sr1mux   = SR1_IR8_6;
        ctrl_s.addr1mux = ADDR1_BASER;
        ctrl_s.addr2mux = A2_ZERO;
        ctrl_s.pcmux    = PC_ADDER;
        ctrl_s.ld_pc    = 1'b1;
      end
      S_HALT: begin
        ctrl_s.halted = 1'b1;
      end
      S_BR, S_INIT: begin
        ctrl_s = CTRL_NONE;
      end
      default: begin
        ctrl_s = CTRL_NONE;
      end
    endcase
  end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 control unit: sequencing, memory-wait timeout and a registered
// control word that changes in lockstep with the state register.
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        ben,
  input  logic        mem_r,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_ben,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        ld_pc,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pcmux,
  output logic [1:0]  drmux,
  output logic [1:0]  sr1mux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        marmux,
  output logic [1:0]  aluk,
  output logic        mio_en,
  output logic        r_w,
  output logic        halted,
  output logic        mem_err,
  output logic [5:0]  state_dbg
);

  localparam logic           TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W:0] LIMIT      = (CNT_W+1)'(MEM_TIMEOUT);

  state_t           state_r;
  state_t           nxt_state_s;
  ctrl_t            ctrl_r;
  ctrl_t            ctrl_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W:0]   cnt_inc_s;
  logic             wait_s;
  logic             timeout_hit_s;
  logic             mem_err_r;
  logic             unused_ir_s;

  // Only the opcode steers sequencing; operand fields are consumed by the datapath.
  assign unused_ir_s = ^ir[11:0];

  assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // Timeout fires on the cycle the wait count would reach the limit with no ready.
  always_comb begin
    wait_s = is_mem_wait(state_r);
    if (TIMEOUT_EN && wait_s && !mem_r && (cnt_inc_s == LIMIT)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Next-state selection; memory completion takes priority over timeout.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      S_INIT:   nxt_state_s = S_FETCH0;
      S_FETCH0: nxt_state_s = S_FETCH1;
      S_FETCH1: begin
        if (mem_r)              nxt_state_s = S_FETCH2;
        else if (timeout_hit_s) nxt_state_s = S_HALT;
        else                    nxt_state_s = S_FETCH1;
      end
      S_FETCH2: nxt_state_s = S_DECODE;
      S_DECODE: nxt_state_s = dispatch(ir[15:12]);
      S_ADD, S_AND, S_NOT, S_LEA, S_JMP, S_LD_W, S_BR_T:
                nxt_state_s = S_FETCH0;
      S_LD_A:   nxt_state_s = S_LD_M;
      S_LD_M: begin
        if (mem_r)              nxt_state_s = S_LD_W;
        else if (timeout_hit_s) nxt_state_s = S_HALT;
        else                    nxt_state_s = S_LD_M;
      end
      S_ST_A:   nxt_state_s = S_ST_D;
      S_ST_D:   nxt_state_s = S_ST_M;
      S_ST_M: begin
        if (mem_r)              nxt_state_s = S_FETCH0;
        else if (timeout_hit_s) nxt_state_s = S_HALT;
        else                    nxt_state_s = S_ST_M;
      end
      S_BR: begin
        if (ben) nxt_state_s = S_BR_T;
        else     nxt_state_s = S_FETCH0;
      end
      S_HALT:   nxt_state_s = S_HALT;
      default:  nxt_state_s = S_HALT;
    endcase
  end

  lc3_ctrl_decode u_decode (
    .state_s (nxt_state_s),
    .ctrl_s  (ctrl_nxt_s)
  );

  // State, wait counter, sticky timeout flag and registered control word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_INIT;
      ctrl_r    <= CTRL_NONE;
      cnt_r     <= '0;
      mem_err_r <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      ctrl_r  <= ctrl_nxt_s;
      if (wait_s && !mem_r && !timeout_hit_s) begin
        cnt_r <= cnt_inc_s[CNT_W-1:0];
      end else begin
        cnt_r <= '0;
      end
      if (timeout_hit_s) begin
        mem_err_r <= 1'b1;
      end
    end
  end

  assign ld_mar      = ctrl_r.ld_mar;
  assign ld_mdr      = ctrl_r.ld_mdr;
  assign ld_ir       = ctrl_r.ld_ir;
  assign ld_ben      = ctrl_r.ld_ben;
  assign ld_reg      = ctrl_r.ld_reg;
  assign ld_cc       = ctrl_r.ld_cc;
  assign ld_pc       = ctrl_r.ld_pc;
  assign gate_pc     = ctrl_r.gate_pc;
  assign gate_mdr    = ctrl_r.gate_mdr;
  assign gate_alu    = ctrl_r.gate_alu;
  assign gate_marmux = ctrl_r.gate_marmux;
  assign pcmux       = ctrl_r.pcmux;
  assign drmux       = ctrl_r.drmux;
  assign sr1mux      = ctrl_r.sr1mux;
  assign addr1mux    = ctrl_r.addr1mux;
  assign addr2mux    = ctrl_r.addr2mux;
  assign marmux      = ctrl_r.marmux;
  assign aluk        = ctrl_r.aluk;
  assign mio_en      = ctrl_r.mio_en;
  assign r_w         = ctrl_r.r_w;
  assign halted      = ctrl_r.halted;
  assign mem_err     = mem_err_r;
  assign state_dbg   = state_r;

endmodule
